// File: rtl/bus_arb_multi.sv
// N-master BR/BG/BGACK bus arbiter for the CPU-side bus.
// Round-robin winner selection, strobe-qualified grant, grant timeout and post-release settle.
module bus_arb_multi #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GRANT_TIMEOUT = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   CLKCPU,
  input  logic                   RESET,
  input  logic [NUM_MASTERS-1:0] BR_N,
  input  logic [NUM_MASTERS-1:0] BGACK_N,
  input  logic                   AS20,
  input  logic                   AS_INT,
  output logic [NUM_MASTERS-1:0] BG_N,
  output logic                   BGACK_INT,
  output logic [2:0]             OWNER,
  output logic                   TIMEOUT
);

  localparam int unsigned TW = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIET,
    S_GRANT,
    S_OWNED,
    S_SETTLE
  } state_t;

  logic [NUM_MASTERS-1:0] br_sync    [SYNC_STAGES];
  logic [NUM_MASTERS-1:0] bgack_sync [SYNC_STAGES];
  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] ack_vec;
  logic [7:0]             req8;
  logic [7:0]             ack8;
  logic                   ack;
  logic                   bus_quiet;

  state_t         state_q, state_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     rr_q, rr_d;
  logic [2:0]     owner_inc;
  logic [2:0]     winner;
  logic           scan_hit;
  logic [3:0]     scan_sum;
  logic [TW-1:0]  timer_q, timer_d;
  logic           timer_expire;
  logic [3:0]     settle_q, settle_d;
  logic           timeout_d;
  logic [7:0]     bg_n8_d;

  // Metastability filter on the asynchronous request/acknowledge lines
  always_ff @(posedge CLKCPU or negedge RESET) begin : sync_chain
    if (!RESET) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        br_sync[s]    <= '1;
        bgack_sync[s] <= '1;
      end
    end else begin
      br_sync[0]    <= BR_N;
      bgack_sync[0] <= BGACK_N;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        br_sync[s]    <= br_sync[s-1];
        bgack_sync[s] <= bgack_sync[s-1];
      end
    end
  end

  assign req_vec   = ~br_sync[SYNC_STAGES-1];
  assign ack_vec   = ~bgack_sync[SYNC_STAGES-1];
  assign req8      = 8'(req_vec);
  assign ack8      = 8'(ack_vec);
  assign ack       = ack8[owner_q];
  assign bus_quiet = AS20 & AS_INT;
  assign owner_inc = (owner_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : owner_q + 3'd1;

  assign timer_expire = (GRANT_TIMEOUT != 0) &&
                        ((32'(timer_q) + 32'd1) >= GRANT_TIMEOUT);

  // First requester at or above rr_q, wrapping at NUM_MASTERS
  always_comb begin : rr_scan
    winner   = rr_q;
    scan_hit = 1'b0;
    scan_sum = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      scan_sum = 4'(rr_q) + 4'(i);
      if (scan_sum >= 4'(NUM_MASTERS)) begin
        scan_sum = scan_sum - 4'(NUM_MASTERS);
      end
      if (!scan_hit && req8[scan_sum[2:0]]) begin
        scan_hit = 1'b1;
        winner   = scan_sum[2:0];
      end
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    timeout_d = 1'b0;
    bg_n8_d   = '1;

    case (state_q)
      S_IDLE: begin
        if (|req_vec) begin
          owner_d = winner;
          state_d = S_QUIET;
        end
      end

      S_QUIET: begin
        if (!req8[owner_q]) begin
          state_d = S_IDLE;
        end else if (bus_quiet) begin
          state_d = S_GRANT;
          timer_d = '0;
        end
      end

      // Acknowledge takes precedence over withdrawal and timeout
      S_GRANT: begin
        if (ack) begin
          state_d = S_OWNED;
        end else if (!req8[owner_q]) begin
          state_d = S_IDLE;
        end else if (timer_expire) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          rr_d      = owner_inc;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_OWNED: begin
        if (!ack) begin
          rr_d = owner_inc;
          if (SETTLE_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_SETTLE;
            settle_d = 4'(SETTLE_CYCLES);
          end
        end
      end

      S_SETTLE: begin
        if (settle_q <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_GRANT) begin
      bg_n8_d[owner_d] = 1'b0;
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin : state_reg
    if (!RESET) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      timer_q   <= '0;
      settle_q  <= '0;
      BG_N      <= '1;
      BGACK_INT <= 1'b1;
      TIMEOUT   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      settle_q  <= settle_d;
      BG_N      <= bg_n8_d[NUM_MASTERS-1:0];
      BGACK_INT <= (state_d != S_OWNED);
      TIMEOUT   <= timeout_d;
    end
  end

  assign OWNER = owner_q;

endmodule

// File: tb/tb_bus_arb_multi.sv
// Bench for bus_arb_multi: directed protocol scenarios plus randomized master behaviour,
// all checked every cycle against a transaction-level arbitration model.
module tb_bus_arb_multi;

  localparam int unsigned N   = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned SET = 2;

  logic         CLKCPU  = 1'b0;
  logic         RESET   = 1'b0;
  logic [N-1:0] BR_N    = '1;
  logic [N-1:0] BGACK_N = '1;
  logic         AS20    = 1'b1;
  logic         AS_INT  = 1'b1;
  logic [N-1:0] BG_N;
  logic         BGACK_INT;
  logic [2:0]   OWNER;
  logic         TIMEOUT;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 CLKCPU = ~CLKCPU;

  bus_arb_multi #(
    .NUM_MASTERS  (N),
    .SYNC_STAGES  (S),
    .GRANT_TIMEOUT(TO),
    .SETTLE_CYCLES(SET)
  ) dut (
    .CLKCPU   (CLKCPU),
    .RESET    (RESET),
    .BR_N     (BR_N),
    .BGACK_N  (BGACK_N),
    .AS20     (AS20),
    .AS_INT   (AS_INT),
    .BG_N     (BG_N),
    .BGACK_INT(BGACK_INT),
    .OWNER    (OWNER),
    .TIMEOUT  (TIMEOUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_WAIT_BUS, P_GRANTED, P_OWNED, P_SETTLE} phase_e;
  phase_e       m_phase = P_IDLE;
  int           m_owner = 0;
  int           m_rr    = 0;
  int           m_timer = 0;
  int           m_settle = 0;
  logic [N-1:0] br_hist[$];
  logic [N-1:0] ack_hist[$];
  logic [N-1:0] exp_bg_n  = '1;
  logic         exp_bgack = 1'b1;
  logic         exp_to    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < int'(N); k++)
      if (r[(from + k) % int'(N)]) return (from + k) % int'(N);
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_owner = 0; m_rr = 0; m_timer = 0; m_settle = 0;
    br_hist.delete(); ack_hist.delete();
    for (int k = 0; k < int'(S); k++) begin
      br_hist.push_back('1);
      ack_hist.push_back('1);
    end
    exp_bg_n = '1; exp_bgack = 1'b1; exp_to = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] req;
    logic [N-1:0] ackv;
    int w;
    req  = ~br_hist[S-1];
    ackv = ~ack_hist[S-1];
    br_hist.push_front(BR_N);     void'(br_hist.pop_back());
    ack_hist.push_front(BGACK_N); void'(ack_hist.pop_back());
    exp_to = 1'b0;
    case (m_phase)
      P_IDLE: begin
        w = pick(req, m_rr);
        if (w >= 0) begin m_owner = w; m_phase = P_WAIT_BUS; end
      end
      P_WAIT_BUS: begin
        if (!req[m_owner]) m_phase = P_IDLE;
        else if (AS20 && AS_INT) begin m_phase = P_GRANTED; m_timer = 0; end
      end
      P_GRANTED: begin
        if (ackv[m_owner]) m_phase = P_OWNED;
        else if (!req[m_owner]) m_phase = P_IDLE;
        else if (TO != 0 && m_timer + 1 >= int'(TO)) begin
          exp_to = 1'b1; m_rr = (m_owner + 1) % int'(N); m_phase = P_IDLE;
        end else m_timer++;
      end
      P_OWNED: begin
        if (!ackv[m_owner]) begin
          m_rr = (m_owner + 1) % int'(N);
          if (SET == 0) m_phase = P_IDLE;
          else begin m_phase = P_SETTLE; m_settle = int'(SET); end
        end
      end
      default: begin
        if (m_settle <= 1) m_phase = P_IDLE;
        else m_settle--;
      end
    endcase
    exp_bg_n = '1;
    if (m_phase == P_GRANTED) exp_bg_n[m_owner] = 1'b0;
    exp_bgack = (m_phase != P_OWNED);
  endtask

  always @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) model_reset();
    else model_step();
  end

  always @(negedge CLKCPU) begin
    if (cmp_en) begin
      chk("model_bg_n", 32'(BG_N), 32'(exp_bg_n));
      chk("model_bgack_int", 32'(BGACK_INT), 32'(exp_bgack));
      chk("model_owner", 32'(OWNER), 32'(m_owner));
      chk("model_timeout", 32'(TIMEOUT), 32'(exp_to));
    end
  end

  // ---------------- stimulus helpers ----------------
  int  resp[N] = '{default: 0};
  int  hold[N] = '{default: 0};
  bit  ign[N]  = '{default: 1'b0};

  task automatic assert_reset();
    @(negedge CLKCPU);
    #2 RESET = 1'b0;
  endtask

  task automatic wait_grant(input string name, output int idx);
    idx = -1;
    for (int n = 0; n < 60 && idx < 0; n++) begin
      @(negedge CLKCPU);
      for (int i = 0; i < int'(N); i++) if (BG_N[i] === 1'b0) idx = i;
    end
    chk({name, "_seen"}, 32'(idx >= 0), 32'd1);
  endtask

  task automatic serve(input int exp_idx);
    int idx;
    int n;
    wait_grant("rr_grant", idx);
    chk("rr_order", 32'(idx), 32'(exp_idx));
    if (idx >= 0) begin
      BGACK_N[idx] = 1'b0;
      n = 0;
      while (BGACK_INT !== 1'b0 && n < 10) begin @(negedge CLKCPU); n++; end
      chk("ack_latency", 32'(n), 32'd3);
      chk("bg_released_on_ack", 32'(BG_N), 32'hF);
      repeat (3) @(negedge CLKCPU);
      BGACK_N[idx] = 1'b1;
    end
  endtask

  task automatic drive_random();
    int r;
    for (int i = 0; i < int'(N); i++) begin
      if (hold[i] > 0) begin
        hold[i]--;
        if (hold[i] == 0) begin
          BGACK_N[i] = 1'b1;
          if ($urandom % 2 == 0) BR_N[i] = 1'b1;
        end
      end else if (resp[i] > 0) begin
        resp[i]--;
        if (resp[i] == 0) begin BGACK_N[i] = 1'b0; hold[i] = 2 + int'($urandom % 6); end
      end else if (BG_N[i] === 1'b0 && !ign[i]) begin
        if ($urandom % 5 == 0) ign[i] = 1'b1;
        else resp[i] = 1 + int'($urandom % 3);
      end else begin
        if (BG_N[i] === 1'b1) ign[i] = 1'b0;
        if ($urandom % 80 == 0) begin BGACK_N[i] = 1'b0; hold[i] = 1; end
        else if (BR_N[i] && $urandom % 8 == 0) BR_N[i] = 1'b0;
        else if (!BR_N[i] && $urandom % 40 == 0) BR_N[i] = 1'b1;
      end
    end
    r = int'($urandom % 10);
    if (r < 6) begin AS20 = 1'b1; AS_INT = 1'b1; end
    else begin AS20 = 1'($urandom % 2); AS_INT = 1'($urandom % 2); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int idx;
    bit held;
    model_reset();

    // Reset with every master requesting
    BR_N = '0;
    repeat (2) @(negedge CLKCPU);
    cmp_en = 1'b1;
    chk("rst_bg_n", 32'(BG_N), 32'hF);
    chk("rst_bgack_int", 32'(BGACK_INT), 32'd1);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    chk("rst_owner", 32'(OWNER), 32'd0);
    RESET = 1'b1;
    n = 0;
    while (BG_N === 4'hF && n < 20) begin @(posedge CLKCPU); #1; n++; end
    chk("rst_to_grant_edges", 32'(n), 32'd4);
    chk("first_grant", 32'(BG_N), 32'hE);

    // Round robin with all masters requesting
    serve(0); serve(1); serve(2); serve(3); serve(0);
    BR_N = '1;
    repeat (12) @(negedge CLKCPU);

    // Strobe disagreement blocks the grant
    assert_reset();
    BR_N = 4'b1110; AS20 = 1'b0; AS_INT = 1'b1;
    repeat (3) @(negedge CLKCPU);
    RESET = 1'b1;
    held = 1'b1;
    repeat (50) begin @(negedge CLKCPU); if (BG_N !== 4'hF) held = 1'b0; end
    chk("mismatch_no_grant", 32'(held), 32'd1);
    AS20 = 1'b1;
    @(negedge CLKCPU);
    chk("grant_after_match", 32'(BG_N), 32'hE);
    BR_N = '1;
    repeat (6) @(negedge CLKCPU);

    // Grant timeout on master 2, then master 3 next
    assert_reset();
    BR_N = 4'b0011;
    repeat (3) @(negedge CLKCPU);
    RESET = 1'b1;
    wait_grant("to_grant", idx);
    chk("to_grant_owner", 32'(idx), 32'd2);
    n = 1;
    while (BG_N[2] === 1'b0 && n < 40) begin
      @(negedge CLKCPU);
      if (BG_N[2] === 1'b0) n++;
    end
    chk("to_grant_cycles", 32'(n), 32'd16);
    chk("to_pulse", 32'(TIMEOUT), 32'd1);
    @(negedge CLKCPU);
    chk("to_pulse_one_cycle", 32'(TIMEOUT), 32'd0);
    wait_grant("post_to_grant", idx);
    chk("post_to_owner", 32'(idx), 32'd3);

    // Reset during tenure drops ownership without a clock edge
    BGACK_N[3] = 1'b0;
    n = 0;
    while (BGACK_INT !== 1'b0 && n < 10) begin @(negedge CLKCPU); n++; end
    chk("owned_reached", 32'(BGACK_INT), 32'd0);
    @(negedge CLKCPU);
    #2 RESET = 1'b0;
    #1;
    chk("midreset_bg_n", 32'(BG_N), 32'hF);
    chk("midreset_bgack_int", 32'(BGACK_INT), 32'd1);
    BGACK_N = '1; BR_N = '1;
    repeat (2) @(negedge CLKCPU);
    RESET = 1'b1;

    // Randomized masters and strobes
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLKCPU);
      drive_random();
    end
    BR_N = '1; BGACK_N = '1; AS20 = 1'b1; AS_INT = 1'b1;
    repeat (10) @(negedge CLKCPU);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
